// File: rtl/curtain_motor_ctrl_if.sv
// Target/status bundle between the light-control logic and the curtain motor sequencer.
interface curtain_motor_ctrl_if #(
  parameter int unsigned POS_W = 16
);
  logic [POS_W-1:0] target;
  logic             target_valid;
  logic             home_sw;
  logic [3:0]       motor_out;
  logic [POS_W-1:0] cur_pos;
  logic             busy;
  logic             at_target;
  logic             fault;

  // Requester side: issues targets and supplies the limit switch.
  modport master (
    output target, target_valid, home_sw,
    input  motor_out, cur_pos, busy, at_target, fault
  );

  // Sequencer side.
  modport slave (
    input  target, target_valid, home_sw,
    output motor_out, cur_pos, busy, at_target, fault
  );
endinterface

// File: rtl/curtain_motor_ctrl.sv
// Closed-loop half-step sequencer: homes against the open-end switch after reset,
// then walks the coil phase pattern toward the stored target at a fixed step rate.
module curtain_motor_ctrl #(
  parameter int unsigned STEP_DIV = 50000,
  parameter int unsigned POS_W    = 16,
  parameter int unsigned POS_MAX  = 4096,
  parameter int unsigned HOME_MAX = 8192
) (
  input logic                 clk,
  input logic                 rst_n,
  curtain_motor_ctrl_if.slave bus
);

  localparam int unsigned DIV_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned HCNT_W = $clog2(HOME_MAX + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(HOME_MAX);
  localparam logic [POS_W-1:0]  POS_LIM   = POS_W'(POS_MAX);
  localparam logic [3:0]        COILS_OFF = 4'b1111;

  typedef enum logic [2:0] {
    StHome,
    StIdle,
    StMoveFwd,
    StMoveBwd,
    StFault
  } state_e;

  // Active-low coil pattern for each half-step phase.
  function automatic logic [3:0] phase_pat(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b0111;
      3'd1:    pat = 4'b0011;
      3'd2:    pat = 4'b1011;
      3'd3:    pat = 4'b1001;
      3'd4:    pat = 4'b1101;
      3'd5:    pat = 4'b1100;
      3'd6:    pat = 4'b1110;
      3'd7:    pat = 4'b0110;
      default: pat = COILS_OFF;
    endcase
    return pat;
  endfunction

  state_e            state_q, state_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [POS_W-1:0]  tgt_q, tgt_d;
  logic [2:0]        phase_q, phase_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [3:0]        motor_q, motor_d;
  logic              busy_q, busy_d;
  logic              at_tgt_q, at_tgt_d;
  logic              fault_q, fault_d;
  logic              div_run;
  logic              tick;

  assign div_run = (state_q == StHome) || (state_q == StMoveFwd) || (state_q == StMoveBwd);
  assign tick    = div_run && (div_q == DIV_LAST);

  // Next-state, position, phase and registered-output computation.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    phase_d = phase_q;
    hcnt_d  = hcnt_q;

    // Target is captured in every state; decisions below use the previous value.
    if (bus.target_valid) begin
      tgt_d = (bus.target > POS_LIM) ? POS_LIM : bus.target;
    end else begin
      tgt_d = tgt_q;
    end

    case (state_q)
      StHome: begin
        if (tick && bus.home_sw) begin
          pos_d   = '0;
          state_d = (tgt_q != '0) ? StMoveFwd : StIdle;
        end else if (!bus.home_sw && (hcnt_q == HCNT_MAX)) begin
          state_d = StFault;
        end else if (tick) begin
          // Position is not trusted yet, so only the phase and the budget move.
          phase_d = phase_q - 3'd1;
          hcnt_d  = hcnt_q + 1'b1;
        end
      end
      StIdle: begin
        if (tgt_q > pos_q) begin
          state_d = StMoveFwd;
        end else if (tgt_q < pos_q) begin
          state_d = StMoveBwd;
        end
      end
      StMoveFwd: begin
        if (tick) begin
          if (tgt_q > pos_q) begin
            if (pos_q < POS_LIM) begin
              pos_d   = pos_q + 1'b1;
              phase_d = phase_q + 3'd1;
            end
          end else if (tgt_q < pos_q) begin
            state_d = StMoveBwd;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StMoveBwd: begin
        if (tick) begin
          if (bus.home_sw) begin
            // Passing the open-end switch re-zeroes the position without stepping.
            pos_d   = '0;
            state_d = (tgt_q == '0) ? StIdle : StMoveFwd;
          end else if (tgt_q < pos_q) begin
            if (pos_q != '0) begin
              pos_d   = pos_q - 1'b1;
              phase_d = phase_q - 3'd1;
            end
          end else if (tgt_q > pos_q) begin
            state_d = StMoveFwd;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StHome;
      end
    endcase

    // Divider restarts on every state change so the first tick is a full period away.
    if (!div_run || tick || (state_d != state_q)) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end

    if ((state_d == StIdle) || (state_d == StFault)) begin
      motor_d = COILS_OFF;
    end else begin
      motor_d = phase_pat(phase_d);
    end
    busy_d   = (state_d != StIdle);
    at_tgt_d = (state_d == StIdle) && (pos_d == tgt_d);
    fault_d  = (state_d == StFault);
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StHome;
      pos_q    <= '0;
      tgt_q    <= '0;
      phase_q  <= 3'd0;
      div_q    <= '0;
      hcnt_q   <= '0;
      motor_q  <= 4'b0111;
      busy_q   <= 1'b1;
      at_tgt_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      tgt_q    <= tgt_d;
      phase_q  <= phase_d;
      div_q    <= div_d;
      hcnt_q   <= hcnt_d;
      motor_q  <= motor_d;
      busy_q   <= busy_d;
      at_tgt_q <= at_tgt_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.motor_out = motor_q;
  assign bus.cur_pos   = pos_q;
  assign bus.busy      = busy_q;
  assign bus.at_target = at_tgt_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_curtain_motor_ctrl.sv
// Self-checking bench for curtain_motor_ctrl: hand-timed sequences, a target table,
// and randomized retargeting checked against a position/phase reference model.
module tb_curtain_motor_ctrl;

  localparam int unsigned STEP_DIV = 4;
  localparam int unsigned POS_W    = 16;
  localparam int unsigned POS_MAX  = 20;
  localparam int unsigned HOME_MAX = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;

  curtain_motor_ctrl_if #(.POS_W(POS_W)) bus ();

  curtain_motor_ctrl #(
    .STEP_DIV(STEP_DIV),
    .POS_W   (POS_W),
    .POS_MAX (POS_MAX),
    .HOME_MAX(HOME_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] ptab [8];

  typedef struct {
    int tgt;
    int exp_pos;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int clamp(input int t);
    return (t > int'(POS_MAX)) ? int'(POS_MAX) : t;
  endfunction

  task automatic strobe(input int t);
    bus.target       = POS_W'(t);
    bus.target_valid = 1'b1;
    @(negedge clk);
    bus.target_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while (bus.busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.busy, 1'b0);
  endtask

  task automatic wait_pos(input int p, input string name);
    int n;
    n = 0;
    while (int'(bus.cur_pos) != p && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.cur_pos, p);
  endtask

  // Reference model after homing with five backward steps: phase index = (3 + pos) mod 8,
  // coils dark whenever idle, single half-steps no closer than one step period.
  bit mon_en = 1'b0;
  int prev_pos;
  int last_step_cyc;
  int mon_p;
  always @(negedge clk) begin
    if (mon_en) begin
      mon_p = int'(bus.cur_pos);
      if (mon_p != prev_pos) begin
        check("step_delta", (mon_p > prev_pos) ? mon_p - prev_pos : prev_pos - mon_p, 1);
        check("pos_bound", mon_p <= int'(POS_MAX), 1'b1);
        check("step_gap", (cyc - last_step_cyc) >= int'(STEP_DIV), 1'b1);
        last_step_cyc = cyc;
        prev_pos      = mon_p;
      end
      if (bus.busy) check("coil_phase", bus.motor_out, ptab[(3 + mon_p) % 8]);
      else          check("coil_off", bus.motor_out, 4'hF);
    end else begin
      prev_pos      = int'(bus.cur_pos);
      last_step_cyc = cyc - int'(STEP_DIV);
    end
  end

  initial begin
    logic [3:0] exp_home [5];
    logic [3:0] prev_m;
    int k, nchg, t_last, t, w, last_t;

    ptab = '{4'b0111, 4'b0011, 4'b1011, 4'b1001, 4'b1101, 4'b1100, 4'b1110, 4'b0110};
    exp_home = '{4'b0110, 4'b1110, 4'b1100, 4'b1101, 4'b1001};
    vecs[0] = '{50, 20};
    vecs[1] = '{9, 9};
    vecs[2] = '{0, 0};
    vecs[3] = '{25, 20};
    vecs[4] = '{11, 11};
    vecs[5] = '{1, 1};

    bus.target       = '0;
    bus.target_valid = 1'b0;
    bus.home_sw      = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_motor", bus.motor_out, 4'b0111);
    check("rst_pos", bus.cur_pos, 0);
    check("rst_busy", bus.busy, 1'b1);
    check("rst_at_target", bus.at_target, 1'b0);
    check("rst_fault", bus.fault, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Homing: five backward steps, then the switch closes
    prev_m = bus.motor_out;
    k = 0; nchg = 0; t_last = 0;
    while (nchg < 5 && k < 60) begin
      @(negedge clk);
      k++;
      if (bus.motor_out != prev_m) begin
        check("home_seq", bus.motor_out, exp_home[nchg]);
        check("home_gap", k - t_last, STEP_DIV);
        t_last = k;
        prev_m = bus.motor_out;
        nchg++;
      end
    end
    check("home_steps", nchg, 5);
    bus.home_sw = 1'b1;
    repeat (STEP_DIV) @(negedge clk);
    check("home_busy", bus.busy, 1'b0);
    check("home_pos", bus.cur_pos, 0);
    check("home_coils", bus.motor_out, 4'hF);
    check("home_at_target", bus.at_target, 1'b1);
    bus.home_sw = 1'b0;
    mon_en = 1'b1;

    // Forward move 0 -> 3 with exact latency
    strobe(3);
    check("fwd_busy_early", bus.busy, 1'b0);
    @(negedge clk);
    check("fwd_busy", bus.busy, 1'b1);
    for (int s = 1; s <= 3; s++) begin
      repeat (STEP_DIV - 1) @(negedge clk);
      check("fwd_hold", bus.cur_pos, s - 1);
      @(negedge clk);
      check("fwd_pos", bus.cur_pos, s);
      check("fwd_coil", bus.motor_out, ptab[(3 + s) % 8]);
    end
    repeat (STEP_DIV - 1) @(negedge clk);
    check("fwd_still_busy", bus.busy, 1'b1);
    @(negedge clk);
    check("fwd_done", bus.busy, 1'b0);
    check("fwd_at_target", bus.at_target, 1'b1);
    check("fwd_coils_off", bus.motor_out, 4'hF);

    // Table of targets, including clamped ones
    for (int i = 0; i < 6; i++) begin
      strobe(vecs[i].tgt);
      wait_idle("tbl_idle");
      check("tbl_pos", bus.cur_pos, vecs[i].exp_pos);
      check("tbl_at_target", bus.at_target, 1'b1);
      check("tbl_coils", bus.motor_out, 4'hF);
    end

    // Clamp and reversal at position 6
    strobe(50);
    wait_pos(6, "rev_reach6");
    strobe(2);
    k = 1;
    while (bus.cur_pos == 6 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rev_gap", k, 2 * STEP_DIV);
    check("rev_first", bus.cur_pos, 5);
    wait_idle("rev_idle");
    check("rev_final", bus.cur_pos, 2);

    // Randomized retargeting, often mid-move
    last_t = 2;
    for (int i = 0; i < 12; i++) begin
      t = int'($urandom_range(POS_MAX + 8, 0));
      strobe(t);
      last_t = t;
      w = int'($urandom_range(60, 3));
      repeat (w) @(negedge clk);
      if (!bus.busy) begin
        check("rnd_pos", bus.cur_pos, clamp(last_t));
        check("rnd_at_target", bus.at_target, 1'b1);
      end
    end
    wait_idle("rnd_idle");
    check("rnd_final", bus.cur_pos, clamp(last_t));
    mon_en = 1'b0;

    // Recalibration on the switch while opening
    strobe(5);
    wait_idle("recal_idle5");
    check("recal_start", bus.cur_pos, 5);
    strobe(0);
    wait_pos(3, "recal_reach3");
    bus.home_sw = 1'b1;
    repeat (STEP_DIV - 1) @(negedge clk);
    check("recal_hold", bus.cur_pos, 3);
    @(negedge clk);
    check("recal_pos", bus.cur_pos, 0);
    check("recal_busy", bus.busy, 1'b0);
    check("recal_coils", bus.motor_out, 4'hF);
    bus.home_sw = 1'b0;
    nchg = 0;
    repeat (3 * STEP_DIV) begin
      @(negedge clk);
      if (bus.motor_out != 4'hF || bus.cur_pos != 0) nchg++;
    end
    check("recal_quiet", nchg, 0);

    // Reset mid-move, then homing without the switch runs into the fault
    strobe(15);
    wait_pos(7, "rstmv_reach7");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rstmv_motor", bus.motor_out, 4'b0111);
    check("rstmv_pos", bus.cur_pos, 0);
    check("rstmv_busy", bus.busy, 1'b1);
    check("rstmv_at_target", bus.at_target, 1'b0);
    check("rstmv_fault", bus.fault, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_m = bus.motor_out;
    k = 0; nchg = 0;
    while (!bus.fault && k < int'(HOME_MAX * STEP_DIV) + 40) begin
      @(negedge clk);
      k++;
      if (bus.motor_out != prev_m) begin
        if (bus.motor_out != 4'hF) begin
          nchg++;
          if (nchg == 1) begin
            check("rehome_first", bus.motor_out, 4'b0110);
            check("rehome_gap", k, STEP_DIV);
          end
        end
        prev_m = bus.motor_out;
      end
    end
    check("fault_steps", nchg, HOME_MAX);
    check("fault_time", k, HOME_MAX * STEP_DIV + 1);
    check("fault_flag", bus.fault, 1'b1);
    check("fault_coils", bus.motor_out, 4'hF);
    check("fault_busy", bus.busy, 1'b1);
    strobe(10);
    nchg = 0;
    repeat (5 * STEP_DIV) begin
      @(negedge clk);
      if (bus.motor_out != 4'hF || bus.cur_pos != 0) nchg++;
    end
    check("fault_no_motion", nchg, 0);
    check("fault_sticky", bus.fault, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/curtain_motor_ctrl.md
# curtain_motor_ctrl

Closed-loop position sequencer for the curtain stepper motor. Accepts a target curtain position in half-steps from the light-control logic and homes the motor against the open-end limit switch after reset. It then walks the 8-phase half-step coil pattern forward or backward at a fixed step rate until the position counter equals the target. It replaces free-running direction modules with a single block that owns `motor_out`.

## Interface
- `STEP_DIV`, 50000: clk cycles per half-step; must be ≥ 2.
- `POS_W`, 16: width of position and target.
- `POS_MAX`, 4096: fully-closed position in half-steps; targets above it are clamped.
- `HOME_MAX`, 8192: maximum backward half-steps allowed while homing before declaring a fault.
- `clk` in 1: system clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `target` in POS_W: requested position; 0 is open, POS_MAX is closed.
- `target_valid` in 1: single-cycle strobe that loads `target`.
- `home_sw` in 1: open-end limit switch, active-high, already synchronised.
- `motor_out` out 4: coil drive, active-low pattern.
- `cur_pos` out POS_W: current position in half-steps.
- `busy` out 1: high in every state except IDLE.
- `at_target` out 1: high in IDLE when `cur_pos` equals the stored target.
- `fault` out 1: high when homing has failed; sticky until reset.

## Operation
- Phase table P[0..7] = 4'b0111, 0011, 1011, 1001, 1101, 1100, 1110, 0110.
  - Forward (closing, `cur_pos`+1) advances phase index by +1 mod 8.
  - Backward (opening, `cur_pos`−1) moves phase index by −1 mod 8, wrapping 0 to 7.
- Coils off = 4'b1111. This is driven in IDLE and FAULT.
- Target register `tgt` loads min(`target`, POS_MAX) on every cycle that `target_valid` is high, in any state. It is applied only outside HOME. The last strobe wins.
- States:
  - HOME: entered on reset.
    - Each step tick with `home_sw`=0 takes one backward step and increments the home step count.
    - A tick with `home_sw`=1 sets `cur_pos`=0 and goes to IDLE, or to a MOVE state if `tgt`≠0.
    - If the home step count reaches HOME_MAX while `home_sw`=0, go to FAULT.
  - IDLE:
    - `tgt`>`cur_pos` → MOVE_FWD.
    - `tgt`<`cur_pos` → MOVE_BWD.
    - Otherwise stay.
  - MOVE_FWD: on each tick, compare first.
    - `tgt`>`cur_pos`: step forward.
    - `tgt`<`cur_pos`: switch to MOVE_BWD with no step this tick.
    - Equal: go to IDLE.
  - MOVE_BWD: on each tick, checks in priority order.
    1. `home_sw`=1: recalibrate `cur_pos`=0 with no step; then go to IDLE if `tgt`=0, else MOVE_FWD.
    2. `tgt`<`cur_pos`: step backward.
    3. `tgt`>`cur_pos`: switch to MOVE_FWD with no step.
    4. Equal: go to IDLE.
  - FAULT: terminal state. `motor_out`=1111, `fault`=1, and `target_valid` is ignored except for loading `tgt`.
- `cur_pos` never decrements below 0 and never increments above POS_MAX.
- The phase index is retained across IDLE. Re-energising resumes from the last phase ±1, so no steps are lost.

## Timing
- Reset values:
  - state = HOME, `cur_pos`=0, `tgt`=0, phase index 0.
  - Step divider = 0, home step count = 0.
  - `motor_out`=4'b0111 (P[0] held while homing), `busy`=1, `at_target`=0, `fault`=0.
- The step divider is active only in HOME, MOVE_FWD and MOVE_BWD.
  - It counts 0..STEP_DIV−1; the tick is the cycle with count = STEP_DIV−1.
  - It clears on every state transition, so the first tick comes exactly STEP_DIV cycles after entering a state.
- Step updates are registered:
  - On a stepping tick, `motor_out` and `cur_pos` change together on the next rising edge.
  - Step period is exactly STEP_DIV cycles.
- The IDLE → MOVE decision takes 1 cycle after `tgt` changes. A `target_valid` in IDLE therefore gives `busy`=1 two edges later, and the first step STEP_DIV cycles after that.
- Leaving MOVE to IDLE: `motor_out` becomes 1111 on the same edge that sets `busy`=0 and `at_target`=1.
- Reversal costs one tick period with no step.
- Asynchronous reset mid-move: outputs go immediately to reset values and homing restarts. The position is not trusted.

## Test plan
Bench settings: STEP_DIV=4, POS_MAX=20, HOME_MAX=32.

- **Homing:** reset, `home_sw` rises after 5 backward ticks.
  - `motor_out` sequence from reset: 0111, 0110, 1110, 1100, 1101, 1001.
  - Then `cur_pos`=0, `busy`=0, `motor_out`=1111.
- **Forward move:** from IDLE at 0, `target`=3 strobe.
  - Three forward steps 4 cycles apart; `cur_pos` counts 1, 2, 3.
  - Then `at_target`=1, `motor_out`=1111.
- **Clamp and reversal:** `target`=50 gives `tgt`=20. At `cur_pos`=6, strobe `target`=2.
  - One tick with no step, then backward steps to 2.
  - `cur_pos` never exceeds 20.
- **Home recalibration:** from `cur_pos`=5 with `tgt`=0, assert `home_sw` at the tick where `cur_pos`=3.
  - `cur_pos` is forced to 0 and the block goes to IDLE with no further steps.
- **Homing fault:** hold `home_sw`=0 through reset.
  - After 32 backward steps: `fault`=1, `motor_out`=1111.
  - A later `target_valid` causes no motion.
- **Reset mid-move:** assert `rst_n`=0 during MOVE_FWD at `cur_pos`=7.
  - Outputs immediately take reset values, and homing restarts after `rst_n` rises.
